// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - RV32I MEM stage: req/ack data bus, lane steering, MEM/WB register.
// Optional bus timeout abort is enabled by defining MEM_TIMEOUT_EN.
module memory_cycle #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  rd_addr_M,
  input  logic [12:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [4:0]  rd_addr_W,
  output logic [12:0] PCPlus4W,
  output logic        misalign_err,
  output logic        timeout_err
);

`ifdef MEM_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT_CYCLES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_next;

  logic        is_load, access, misalign;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic        hold_we;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_be;
  logic [4:0]  wait_cnt;
  logic        timeout_hit, timeout_fire;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign is_load = (ResultSrcM == 2'b01);
  assign access  = MemWriteM | is_load;

  always_comb begin
    misalign = 1'b0;
    case (funct3M[1:0])
      2'b01:   misalign = ALUResultM[0];
      2'b10:   misalign = (ALUResultM[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end

  always_comb begin
    st_wdata = WriteDataM;
    st_be    = 4'b1111;
    case (funct3M[1:0])
      2'b00: begin
        st_wdata = {4{WriteDataM[7:0]}};
        st_be    = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        st_wdata = {2{WriteDataM[15:0]}};
        st_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // The last WAIT cycle aborts unless the ack shows up in that same cycle.
  assign timeout_hit  = TIMEOUT_EN && (state == S_WAIT) && (wait_cnt == TIMEOUT_LAST);
  assign timeout_fire = timeout_hit & ~dmem_ack;

  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && !misalign) begin
          dmem_req = 1'b1;
          if (!dmem_ack) state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_next = S_IDLE;
        end else if (timeout_hit) begin
          dmem_req   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (rst) dmem_req = 1'b0;
  end

  assign dmem_we    = (state == S_WAIT) ? hold_we    : MemWriteM;
  assign dmem_addr  = (state == S_WAIT) ? hold_addr  : {ALUResultM[31:2], 2'b00};
  assign dmem_wdata = (state == S_WAIT) ? hold_wdata : st_wdata;
  assign dmem_be    = (state == S_WAIT) ? hold_be    : st_be;

  assign StallM = access & ~misalign & dmem_req & ~dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= 5'd0;
      hold_we    <= 1'b0;
      hold_addr  <= 32'd0;
      hold_wdata <= 32'd0;
      hold_be    <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == S_IDLE) ? 5'd0 : wait_cnt + 5'd1;
      if (state == S_IDLE) begin
        hold_we    <= MemWriteM;
        hold_addr  <= {ALUResultM[31:2], 2'b00};
        hold_wdata <= st_wdata;
        hold_be    <= st_be;
      end
    end
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (ALUResultM[1:0])
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = ALUResultM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3M)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'd0, ld_byte};
      3'b101:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Dropped (misaligned or timed-out) accesses still retire, just without a register write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'b00;
      ALUResultW   <= 32'd0;
      ReadDataW    <= 32'd0;
      rd_addr_W    <= 5'd0;
      PCPlus4W     <= 13'd0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      RegWriteW    <= RegWriteM & ~StallM & ~(access & misalign) & ~timeout_fire;
      ResultSrcW   <= ResultSrcM;
      ALUResultW   <= ALUResultM;
      ReadDataW    <= load_data;
      rd_addr_W    <= rd_addr_M;
      PCPlus4W     <= PCPlus4M;
      misalign_err <= access & misalign;
      timeout_err  <= timeout_fire;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - randomized self-checking bench for memory_cycle against a transaction model.
module tb_memory_cycle;

`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  rd_addr_M;
  logic [12:0] PCPlus4M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW;
  logic [4:0]  rd_addr_W;
  logic [12:0] PCPlus4W;
  logic        misalign_err, timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  memory_cycle #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .rd_addr_M(rd_addr_M), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .StallM(StallM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .rd_addr_W(rd_addr_W), .PCPlus4W(PCPlus4W), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one instruction; the bus answers after d cycles (ack in cycle d).
  task automatic run_instr(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                           input logic [12:0] pc4, input logic [31:0] rdata, input int d);
    bit is_ld, acc, mis, ok, to, done;
    int size, off;
    longint val;
    logic [31:0] exp_ld, exp_wdata;
    logic [3:0]  exp_be;
    is_ld = (rs == 2'b01);
    acc   = mw || is_ld;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = int'(addr[1:0]);
    mis   = acc && ((off % size) != 0);
    ok    = acc && !mis;
    to    = ok && TMO_EN && (d > TMO);
    val   = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
    if (size < 4 && !f3[2] && val >= (64'd1 << (8 * size - 1))) val = val - (64'd1 << (8 * size));
    exp_ld = 32'(val);
    exp_be = 4'(((1 << size) - 1) << off);
    exp_wdata = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; funct3M = f3;
    ALUResultM = addr; WriteDataM = wd; rd_addr_M = rd; PCPlus4M = pc4; dmem_rdata = rdata;
    for (int c = 0; c < 200; c++) begin
      bit stall_exp, req_exp;
      dmem_ack  = ok && (c == d);
      req_exp   = ok && !(to && c == TMO);
      stall_exp = ok && (c < d) && !(to && c == TMO);
      #1;
      check("stall", StallM, stall_exp);
      check("req", dmem_req, req_exp);
      if (req_exp) begin
        check("addr", dmem_addr, {addr[31:2], 2'b00});
        check("we", dmem_we, mw);
        if (mw) begin
          check("be", dmem_be, exp_be);
          check("wdata", dmem_wdata, exp_wdata);
        end
      end
      done = !stall_exp;
      @(posedge clk); #1;
      check("rw_w", RegWriteW, done ? (rw && !mis && !to) : 1'b0);
      check("mis_err", misalign_err, mis);
      check("tmo_err", timeout_err, done && to);
      if (done) begin
        check("alu_w", ALUResultW, addr);
        check("rs_w", ResultSrcW, rs);
        check("rd_w", rd_addr_W, rd);
        check("pc4_w", PCPlus4W, pc4);
        if (is_ld && ok && !to) check("ld_w", ReadDataW, exp_ld);
        break;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  task automatic random_instr();
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int kind, d;
    logic rw, mw;
    logic [1:0] rs;
    logic [2:0] f3;
    kind = $urandom % 3;
    d    = ($urandom % 8 == 0) ? 6 : int'($urandom % 4);
    if (kind == 0) begin
      mw = 1'b0; rs = ($urandom % 2) ? 2'b10 : 2'b00; f3 = 3'($urandom); rw = 1'($urandom);
    end else if (kind == 1) begin
      mw = 1'b0; rs = 2'b01; f3 = ld_f3[$urandom % 5]; rw = 1'b1;
    end else begin
      mw = 1'b1; rs = 2'b00; f3 = 3'($urandom % 3); rw = 1'b0;
    end
    run_instr(rw, mw, rs, f3, $urandom, $urandom, 5'($urandom), 13'($urandom), $urandom, d);
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = 3'b010;
    ALUResultM = '0; WriteDataM = '0; rd_addr_M = '0; PCPlus4M = '0;
    #12;
    check("rst_rw_w", RegWriteW, 1'b0);
    check("rst_alu_w", ALUResultW, 32'd0);
    check("rst_mis", misalign_err, 1'b0);
    check("rst_tmo", timeout_err, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_instr(1'b1, 1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 5'd5, 13'h104, 32'hDEADBEEF, 0);
    run_instr(1'b1, 1'b0, 2'b01, 3'b000, 32'h103, 32'h0, 5'd6, 13'h108, 32'h80112233, 3);
    run_instr(1'b0, 1'b1, 2'b00, 3'b001, 32'h22, 32'h0000ABCD, 5'd0, 13'h10C, 32'h0, 1);
    run_instr(1'b1, 1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 5'd7, 13'h110, 32'h12345678, 0);
    run_instr(1'b1, 1'b0, 2'b10, 3'b000, 32'h5, 32'h0, 5'd8, 13'h114, 32'h0, 0);
    run_instr(1'b1, 1'b0, 2'b01, 3'b101, 32'h206, 32'h0, 5'd9, 13'h118, 32'h9ABC1234, 2);
`ifdef MEM_TIMEOUT_EN
    run_instr(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd10, 13'h11C, 32'h0, 99);
    run_instr(1'b1, 1'b0, 2'b01, 3'b010, 32'h304, 32'h0, 5'd11, 13'h120, 32'hCAFEF00D, TMO);
`else
    run_instr(1'b1, 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 5'd10, 13'h11C, 32'hCAFEF00D, 20);
`endif

    for (int i = 0; i < 80; i++) random_instr();

    // Reset in the middle of a WAIT.
    @(negedge clk);
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010;
    ALUResultM = 32'h400; rd_addr_M = 5'd3; PCPlus4M = 13'h1FF; dmem_ack = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_req", dmem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", dmem_req, 1'b0);
    check("rst_rs_w", ResultSrcW, 2'b00);
    check("rst_rd_w", rd_addr_W, 5'd0);
    check("rst_pc4_w", PCPlus4W, 13'd0);
    check("rst_ld_w", ReadDataW, 32'd0);
    @(negedge clk);
    rst = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
    #1;
    check("idle_after_rst", dmem_req, 1'b0);
    check("no_stall_after_rst", StallM, 1'b0);
    run_instr(1'b1, 1'b0, 2'b01, 3'b100, 32'h401, 32'h0, 5'd4, 13'h200, 32'h0000F100, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
